// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: per-source FIFOs, round-robin grant,
// a registered single write port and a pending-write mask for decode stalls.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2,
  localparam int NREG  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pending_mask,
  output logic              idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Index 0 is source A (ALU), index 1 is source B (load).
  logic [ADDR_W-1:0] regMem_q  [2][DEPTH];
  logic [DATA_W-1:0] dataMem_q [2][DEPTH];
  logic [PTR_W-1:0]  rdPtr_q   [2];
  logic [PTR_W-1:0]  wrPtr_q   [2];
  logic [CNT_W-1:0]  count_q   [2];

  logic              rrPtr_q, rrPtr_d;
  logic              rfWe_q;
  logic [ADDR_W-1:0] rfWaddr_q;
  logic [DATA_W-1:0] rfWdata_q;

  logic [ADDR_W-1:0] inReg  [2];
  logic [DATA_W-1:0] inData [2];
  logic [1:0]        full, nonEmpty, push, grant;
  logic [ADDR_W-1:0] headReg;
  logic [DATA_W-1:0] headData;

  // Readiness depends only on registered occupancy; a full FIFO never takes a
  // new entry even when it is being popped on the same edge.
  always_comb begin
    inReg[0]  = a_reg;
    inReg[1]  = b_reg;
    inData[0] = a_data;
    inData[1] = b_data;
    for (int s = 0; s < 2; s++) begin
      full[s]     = (count_q[s] == CNT_W'(DEPTH));
      nonEmpty[s] = (count_q[s] != '0);
    end
    push[0] = a_valid && !full[0];
    push[1] = b_valid && !full[1];
  end

  assign a_ready = reset && !full[0];
  assign b_ready = reset && !full[1];

  // rrPtr_q names the source that wins when both FIFOs hold entries.
  always_comb begin
    grant   = 2'b00;
    rrPtr_d = rrPtr_q;
    if (nonEmpty[0] && (!nonEmpty[1] || !rrPtr_q)) begin
      grant[0] = 1'b1;
    end else if (nonEmpty[1]) begin
      grant[1] = 1'b1;
    end
    if (grant[0]) begin
      rrPtr_d = 1'b1;
    end else if (grant[1]) begin
      rrPtr_d = 1'b0;
    end
    headReg  = grant[1] ? regMem_q[1][rdPtr_q[1]]  : regMem_q[0][rdPtr_q[0]];
    headData = grant[1] ? dataMem_q[1][rdPtr_q[1]] : dataMem_q[0][rdPtr_q[0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        rdPtr_q[s] <= '0;
        wrPtr_q[s] <= '0;
        count_q[s] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          regMem_q[s][i]  <= '0;
          dataMem_q[s][i] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          regMem_q[s][wrPtr_q[s]]  <= inReg[s];
          dataMem_q[s][wrPtr_q[s]] <= inData[s];
          wrPtr_q[s]               <= wrPtr_q[s] + 1'b1;
        end
        if (grant[s]) begin
          rdPtr_q[s] <= rdPtr_q[s] + 1'b1;
        end
        if (push[s] && !grant[s]) begin
          count_q[s] <= count_q[s] + 1'b1;
        end else if (!push[s] && grant[s]) begin
          count_q[s] <= count_q[s] - 1'b1;
        end
      end
    end
  end

  // Address and data hold their last written values between grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr_q   <= 1'b0;
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      rfWe_q  <= |grant;
      if (|grant) begin
        rfWaddr_q <= headReg;
        rfWdata_q <= headData;
      end
    end
  end

  assign rf_we    = rfWe_q;
  assign rf_waddr = rfWaddr_q;
  assign rf_wdata = rfWdata_q;
  assign idle     = !nonEmpty[0] && !nonEmpty[1] && !rfWe_q;

  // Live entries sit at rdPtr, rdPtr+1, ... for count slots (modulo DEPTH).
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot         = '0;
    pending_mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot = rdPtr_q[s] + PTR_W'(i);
        if (CNT_W'(i) < count_q[s]) begin
          pending_mask[regMem_q[s][slot]] = 1'b1;
        end
      end
    end
    if (rfWe_q) begin
      pending_mask[rfWaddr_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-based reference model
// predicts every register-file write; a monitor compares outputs each cycle.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int NREG   = 8;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic              a_valid = 1'b0;
  logic [ADDR_W-1:0] a_reg   = '0;
  logic [DATA_W-1:0] a_data  = '0;
  logic              b_valid = 1'b0;
  logic [ADDR_W-1:0] b_reg   = '0;
  logic [DATA_W-1:0] b_data  = '0;
  logic              a_ready, b_ready, rf_we, idle;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0]   pending_mask;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask), .idle(idle)
  );

  int errors = 0;
  int checks = 0;

  // Entries are {reg, data}; the model queues mirror what each source has
  // handed over but not yet seen written.
  logic [10:0] qA[$], qB[$], expQ[$];
  logic [7:0]  seenData[$];
  bit          preferB = 1'b0;
  bit          mWe = 1'b0;
  bit          sawANotReady = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per rising edge using the pre-edge queue state.
  initial begin
    bit          pA, pB;
    logic [10:0] w;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        qA.delete(); qB.delete(); expQ.delete();
        preferB = 1'b0;
        mWe     = 1'b0;
      end else begin
        pA = a_valid && (qA.size() < DEPTH);
        pB = b_valid && (qB.size() < DEPTH);
        mWe = 1'b0;
        if (qA.size() > 0 && (qB.size() == 0 || !preferB)) begin
          w = qA.pop_front();
          expQ.push_back(w);
          mWe = 1'b1;
          preferB = 1'b1;
        end else if (qB.size() > 0) begin
          w = qB.pop_front();
          expQ.push_back(w);
          mWe = 1'b1;
          preferB = 1'b0;
        end
        if (pA) qA.push_back({a_reg, a_data});
        if (pB) qB.push_back({b_reg, b_data});
      end
    end
  end

  // Monitor: compares the write port against the scoreboard and status outputs
  // against the model state, away from the active edge.
  initial begin
    logic [10:0]     w;
    logic [NREG-1:0] expMask;
    forever begin
      @(negedge clk);
      #2;
      checkOutput("rf_we", rf_we, mWe);
      if (rf_we) begin
        seenData.push_back(rf_wdata);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h expected no write at %0t",
                   rf_waddr, rf_wdata, $time);
        end else begin
          w = expQ.pop_front();
          checkOutput("rf_waddr", rf_waddr, w[10:8]);
          checkOutput("rf_wdata", rf_wdata, w[7:0]);
        end
      end
      expMask = '0;
      foreach (qA[i]) expMask[qA[i][10:8]] = 1'b1;
      foreach (qB[i]) expMask[qB[i][10:8]] = 1'b1;
      if (rf_we && mWe) expMask[rf_waddr] = 1'b1;
      checkOutput("pending_mask", pending_mask, expMask);
      checkOutput("a_ready", a_ready, reset && (qA.size() < DEPTH));
      checkOutput("b_ready", b_ready, reset && (qB.size() < DEPTH));
      checkOutput("idle", idle, (qA.size() == 0) && (qB.size() == 0) && !mWe);
      if (reset && !a_ready) sawANotReady = 1'b1;
    end
  end

  task automatic applyStimulus(input bit av, input logic [2:0] ar, input logic [7:0] ad,
                               input bit bv, input logic [2:0] br, input logic [7:0] bd);
    @(negedge clk);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  // Streams nA/nB incrementing values, advancing only on accepted handshakes.
  task automatic streamBoth(input int nA, input logic [2:0] rA, input logic [7:0] baseA,
                            input int nB, input logic [2:0] rB, input logic [7:0] baseB);
    int ia = 0;
    int ib = 0;
    bit accA, accB;
    for (int cyc = 0; cyc < 64 && (ia < nA || ib < nB); cyc++) begin
      @(negedge clk);
      a_valid = (ia < nA); a_reg = rA; a_data = baseA + 8'(ia);
      b_valid = (ib < nB); b_reg = rB; b_data = baseB + 8'(ib);
      accA = a_valid && a_ready;
      accB = b_valid && b_ready;
      @(posedge clk);
      if (accA) ia++;
      if (accB) ib++;
    end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    checkOutput("stream_accepted_all", ((ia == nA) && (ib == nB)) ? 1 : 0, 1);
  endtask

  initial begin
    logic [7:0] contExp [8];
    logic [7:0] aSeen[$];
    contExp = '{8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23, 8'h14, 8'h24};

    // Reset held with both sources requesting.
    #1;
    reset = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_a_ready", a_ready, 0);
    checkOutput("reset_b_ready", b_ready, 0);
    checkOutput("reset_rf_we", rf_we, 0);
    checkOutput("reset_mask", pending_mask, 0);
    checkOutput("reset_idle", idle, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #3;
    checkOutput("release_a_ready", a_ready, 1);
    checkOutput("release_b_ready", b_ready, 1);

    // Single write from A: r3 = 0x5A.
    applyStimulus(1, 3, 8'h5A, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("single_mask_queued", pending_mask, 8'h08);
    checkOutput("single_no_bypass", rf_we, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("single_we", rf_we, 1);
    checkOutput("single_waddr", rf_waddr, 3);
    checkOutput("single_wdata", rf_wdata, 8'h5A);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("single_mask_clear", pending_mask, 0);
    checkOutput("single_idle", idle, 1);

    // Contention from a fresh round-robin state.
    doReset(1);
    seenData.delete();
    streamBoth(4, 1, 8'h11, 4, 2, 8'h21);
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("contention_count", seenData.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < seenData.size()) checkOutput($sformatf("contention_order_%0d", i), seenData[i], contExp[i]);
    end

    // Backpressure: A fills its FIFO while alternating with B.
    doReset(1);
    seenData.delete();
    sawANotReady = 1'b0;
    streamBoth(6, 4, 8'h01, 6, 6, 8'h41);
    repeat (10) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("backpressure_a_ready_dropped", sawANotReady, 1);
    aSeen.delete();
    foreach (seenData[i]) if (seenData[i] < 8'h40) aSeen.push_back(seenData[i]);
    checkOutput("backpressure_a_count", aSeen.size(), 6);
    foreach (aSeen[i]) checkOutput($sformatf("backpressure_a_order_%0d", i), aSeen[i], 8'(i + 1));

    // Same-register conflict with A preferred.
    doReset(1);
    seenData.delete();
    applyStimulus(1, 5, 8'h7F, 1, 5, 8'h80);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("conflict_mask_queued", pending_mask[5], 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("conflict_first_data", rf_wdata, 8'h7F);
    checkOutput("conflict_mask_first", pending_mask[5], 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("conflict_second_we", rf_we, 1);
    checkOutput("conflict_second_data", rf_wdata, 8'h80);
    checkOutput("conflict_mask_second", pending_mask[5], 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("conflict_mask_clear", pending_mask, 0);

    // Mid-operation reset discards queued work and restores A preference.
    applyStimulus(1, 2, 8'h31, 1, 4, 8'h32);
    applyStimulus(1, 2, 8'h33, 0, 0, 0);
    doReset(1);
    seenData.delete();
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("midreset_no_writes", seenData.size(), 0);
    checkOutput("midreset_mask", pending_mask, 0);
    checkOutput("midreset_idle", idle, 1);
    applyStimulus(1, 1, 8'h44, 1, 2, 8'h55);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("midreset_write_count", seenData.size(), 2);
    if (seenData.size() > 0) checkOutput("midreset_a_first", seenData[0], 8'h44);

    // Randomized traffic with occasional resets, checked by the scoreboard.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      a_valid = ($urandom_range(0, 99) < 60);
      a_reg   = 3'($urandom_range(0, 7));
      a_data  = 8'($urandom);
      b_valid = ($urandom_range(0, 99) < 50);
      b_reg   = 3'($urandom_range(0, 7));
      b_data  = 8'($urandom);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 59) == 0) reset = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) applyStimulus(0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("final_drain", expQ.size(), 0);
    checkOutput("final_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (we / waddr / wdata) between two writeback sources.
  - Source A: ALU writeback.
  - Source B: load/memory writeback.
- Each source has a valid/ready interface backed by a small FIFO.
- Round-robin arbitration grants at most one write per cycle.
- A pending-write mask lets decode stall reads of registers with queued writes.

Parameters:
- DATA_W, 8: write data width (signed, passed through unchanged).
- ADDR_W, 3: register address width; NREG = 2**ADDR_W.
- DEPTH, 2: per-source FIFO depth; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = asserted).
- a_valid  input  1  source A write request.
- a_ready  output  1  source A FIFO can accept.
- a_reg  input  ADDR_W  source A destination register.
- a_data  input  DATA_W  source A write data.
- b_valid  input  1  source B write request.
- b_ready  output  1  source B FIFO can accept.
- b_reg  input  ADDR_W  source B destination register.
- b_data  input  DATA_W  source B write data.
- rf_we  output  1  register-file write enable (RegWrite).
- rf_waddr  output  ADDR_W  register-file write address.
- rf_wdata  output  DATA_W  register-file write data.
- pending_mask  output  NREG  bit r = 1 while any write to register r is queued or on the output.
- idle  output  1  both FIFOs empty and rf_we = 0.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Both FIFOs are emptied and their pointers/counts cleared; rr_ptr = 0 (A preferred).
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - pending_mask = 0, idle = 1.
  - a_ready = b_ready = 0 while reset is asserted.
  - Reset mid-operation discards all queued writes; no rf_we pulse follows the release.
- Accept:
  - x_ready = !fifo_x_full (registered state only; no combinational path from x_valid).
  - A push happens on an edge where x_valid && x_ready.
  - A full FIFO does not accept even if it pops in the same cycle.
- Arbitration, evaluated each cycle on FIFO state before the edge:
  - Neither FIFO non-empty: no grant.
  - Exactly one non-empty: grant that source.
  - Both non-empty: grant the source selected by rr_ptr (0 = A, 1 = B).
  - After any grant, rr_ptr points to the non-granted source.
- Output stage:
  - On an edge with a grant, the head entry of the granted FIFO is popped and registered into rf_waddr / rf_wdata, and rf_we = 1 for exactly one cycle.
  - On an edge with no grant, rf_we = 0; rf_waddr and rf_wdata hold their last values.
- Latency and throughput:
  - Request accepted at edge t: earliest rf_we = 1 is in the cycle following edge t+1 (2 cycles from valid to write). There is no input-to-output bypass.
  - Aggregate throughput is 1 write per cycle; each source sustains 1 per 2 cycles under contention.
- Ordering:
  - Per-source order is FIFO.
  - Cross-source order, including two writes to the same register, is the arbitration order only.
- pending_mask:
  - Combinational OR over the decoded reg fields of all valid entries in both FIFOs, plus rf_waddr when rf_we = 1.
  - A bit set by a push is visible in the cycle after the accepting edge.
  - A bit clears in the cycle after its last write's rf_we cycle, if no other entry targets that register.
- Simultaneous push and pop on the same FIFO: both occur; count is unchanged.
- Pointer wrap-around: FIFO pointers wrap modulo DEPTH; full/empty are derived from a count or an extra pointer bit.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with a_valid = b_valid = 1 -> a_ready = b_ready = 0, rf_we = 0, pending_mask = 0x00, idle = 1. Release reset -> a_ready = b_ready = 1.
- Single write: A pushes r3 = 0x5A at edge t ->
  - pending_mask = 0x08 after t;
  - rf_we = 1, rf_waddr = 3, rf_wdata = 0x5A in the cycle after t+1;
  - pending_mask = 0x00 and idle = 1 after t+2.
- Contention: A (r1, data 0x11..0x14) and B (r2, data 0x21..0x24) held valid continuously -> rf_wdata sequence 0x11, 0x21, 0x12, 0x22, 0x13, 0x23, 0x14, 0x24, with no gaps once both FIFOs are non-empty.
- Backpressure: with both sources streaming, A's FIFO reaches DEPTH = 2 -> a_ready drops to 0. Every accepted A value (0x01..0x06) is written exactly once, in order.
- Same-register conflict, rr_ptr = 0: A r5 = 0x7F and B r5 = 0x80 pushed on the same edge ->
  - writes 0x7F then 0x80 on consecutive cycles;
  - pending_mask bit 5 stays 1 until after the second rf_we cycle.
- Mid-operation reset: 2 entries queued in A and 1 in B, reset = 0 for one cycle -> rf_we stays 0 afterwards, pending_mask = 0x00, rr_ptr = 0 (next contended grant goes to A).
